// File: rtl/kbd_pkg.sv
// Shared PS/2 byte constants, prefix-FSM state type and key-event record for the
// keyboard event path (kbd_event_filter and kbd_event_fifo).
package kbd_pkg;

  localparam logic [7:0] BREAK  = 8'hF0;
  localparam logic [7:0] EXT    = 8'hE0;
  localparam logic [7:0] BAT_OK = 8'hAA;
  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;
  localparam logic [7:0] ECHO   = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kbd_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  // Keyboard status/handshake bytes that never carry a key when seen outside a prefix.
  function automatic logic is_status_byte(input logic [7:0] b);
    return b inside {BAT_OK, ACK, RESEND, ECHO, 8'h00, 8'hFF};
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Small synchronous FIFO of key events; head is presented combinationally and
// popped with a valid/ready handshake. A push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  kbd_event_t push_data,
  input  logic       pop_ready,
  output kbd_event_t head_data,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  kbd_event_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop_ready && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; head_data is forced to zero while empty,
  // so stale or unknown entries are never visible downstream.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/kbd_event_filter.sv
// Turns raw PS/2 scancode bytes into buffered make events, dropping breaks, status
// bytes and (optionally) typematic repeats. E0-prefix support: KBD_EXT_PREFIX_EN.
module kbd_event_filter
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DROP_REPEAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flag,
  input  logic [7:0] scancode,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       overflow
);

`ifdef KBD_EXT_PREFIX_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif
  localparam logic DROP_EN = (DROP_REPEAT != 0);

  kbd_state_e state;
  kbd_state_e state_next;
  logic       make_req;
  logic       make_ext;
  logic       brk_req;
`ifdef KBD_EXT_PREFIX_EN
  logic       brk_ext;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_next = state;
    make_req   = 1'b0;
    make_ext   = 1'b0;
    brk_req    = 1'b0;
`ifdef KBD_EXT_PREFIX_EN
    brk_ext    = 1'b0;
`endif
    if (flag) begin
      case (state)
        ST_IDLE: begin
          if (scancode == BREAK) begin
            state_next = ST_BRK;
          end else if (scancode == EXT) begin
`ifdef KBD_EXT_PREFIX_EN
            state_next = ST_EXT;
`else
            state_next = ST_IDLE;
`endif
          end else if (!is_status_byte(scancode)) begin
            make_req = 1'b1;
          end
        end
        ST_BRK: begin
          brk_req    = 1'b1;
          state_next = ST_IDLE;
        end
`ifdef KBD_EXT_PREFIX_EN
        ST_EXT: begin
          if (scancode == BREAK) begin
            state_next = ST_EXT_BRK;
          end else if (scancode == EXT) begin
            state_next = ST_EXT;
          end else begin
            make_req   = 1'b1;
            make_ext   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          brk_req    = 1'b1;
          brk_ext    = 1'b1;
          state_next = ST_IDLE;
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Last pushed make, used to recognise typematic repeats until its break arrives.
  logic       held_valid;
  logic [7:0] held_code;
  logic       make_match;
  logic       brk_match;
  logic       push;
  logic       fifo_full;
  logic       fifo_empty;
  kbd_event_t push_data;
  kbd_event_t head;

`ifdef KBD_EXT_PREFIX_EN
  logic       held_ext;
  assign make_match = held_valid && (held_code == scancode) && (held_ext == make_ext);
  assign brk_match  = held_valid && (held_code == scancode) && (held_ext == brk_ext);
`else
  assign make_match = held_valid && (held_code == scancode);
  assign brk_match  = held_valid && (held_code == scancode);
`endif

  assign push = make_req && !(DROP_EN && make_match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid <= 1'b0;
      held_code  <= '0;
`ifdef KBD_EXT_PREFIX_EN
      held_ext   <= 1'b0;
`endif
    end else if (push) begin
      held_valid <= 1'b1;
      held_code  <= scancode;
`ifdef KBD_EXT_PREFIX_EN
      held_ext   <= make_ext;
`endif
    end else if (brk_req && brk_match) begin
      held_valid <= 1'b0;
    end
  end

  // A full FIFO only loses the event when nothing is popped in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              overflow <= 1'b0;
    else if (push && fifo_full && !ev_ready) overflow <= 1'b1;
  end

  assign push_data = '{ext: make_ext, code: scancode};

  kbd_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop_ready(ev_ready),
    .head_data(head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head.code;
  assign ev_ext   = EXT_EN & head.ext;

endmodule

// File: tb/tb_kbd_event_filter.sv
// Self-checking bench for kbd_event_filter: directed vector table, hand-written
// prefix/reset/full-FIFO sequences, then random bytes against a queue-based model.
module tb_kbd_event_filter;

  localparam int DEPTH = 4;
  localparam bit DROP  = 1'b1;
`ifdef KBD_EXT_PREFIX_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flag = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       overflow;

  kbd_event_filter #(
    .FIFO_DEPTH (DEPTH),
    .DROP_REPEAT(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flag    (flag),
    .scancode(scancode),
    .ev_ready(ev_ready),
    .ev_valid(ev_valid),
    .ev_code (ev_code),
    .ev_ext  (ev_ext),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit v, input logic [7:0] c,
                            input bit x, input bit o);
    check({tag, ".valid"}, 32'(ev_valid), 32'(v));
    check({tag, ".code"},  32'(ev_code),  32'(c));
    check({tag, ".ext"},   32'(ev_ext),   32'(x));
    check({tag, ".ovf"},   32'(overflow), 32'(o));
  endtask

  // Apply inputs for one clock, return 1 time unit after the edge that consumed them.
  task automatic drive(input bit f, input logic [7:0] b, input bit r);
    flag = f; scancode = b; ev_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    flag = 1'b0; ev_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed { bit ext; bit [7:0] code; } ev_t;
  ev_t q[$];
  bit  m_ovf, m_pend_brk, m_pend_ext, h_valid;
  ev_t h;

  function automatic void model_clear();
    q.delete();
    m_ovf = 0; m_pend_brk = 0; m_pend_ext = 0; h_valid = 0; h = '0;
  endfunction

  function automatic bit is_status(input bit [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  function automatic void model_edge(input bit f, input bit [7:0] b, input bit r);
    bit  pop, push_ok;
    ev_t m;
    pop = r && (q.size() != 0);
    push_ok = 0;
    m = '0;
    if (f) begin
      if (m_pend_brk) begin
        if (h_valid && h.code == b && h.ext == m_pend_ext) h_valid = 0;
        m_pend_brk = 0; m_pend_ext = 0;
      end else if (b == 8'hF0) begin
        m_pend_brk = 1;
      end else if (b == 8'hE0 && EXT_EN) begin
        m_pend_ext = 1;
      end else if (!m_pend_ext && (is_status(b) || b == 8'hE0)) begin
        // status byte or unsupported prefix: ignored
      end else begin
        m = '{ext: m_pend_ext, code: b};
        m_pend_ext = 0;
        if (!(DROP && h_valid && h == m)) begin
          h = m; h_valid = 1;
          if (q.size() < DEPTH || pop) push_ok = 1;
          else m_ovf = 1;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (push_ok) q.push_back(m);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         f;
    logic [7:0] b;
    bit         r;
    bit         v;
    logic [7:0] c;
    bit         o;
  } vec_t;

  vec_t       tbl[18];
  logic [7:0] drain[4];
  logic [7:0] fill[4];
  bit [7:0]   pool[10];

  initial begin
    bit         rf, rr;
    bit [7:0]   rb;

    tbl[0]  = '{1, 8'h1C, 0, 1, 8'h1C, 0};
    tbl[1]  = '{1, 8'h1C, 0, 1, 8'h1C, 0};
    tbl[2]  = '{1, 8'h1C, 0, 1, 8'h1C, 0};
    tbl[3]  = '{1, 8'hF0, 0, 1, 8'h1C, 0};
    tbl[4]  = '{1, 8'h1C, 0, 1, 8'h1C, 0};
    tbl[5]  = '{1, 8'h1C, 0, 1, 8'h1C, 0};
    tbl[6]  = '{0, 8'h00, 1, 1, 8'h1C, 0};
    tbl[7]  = '{0, 8'h00, 1, 0, 8'h00, 0};
    tbl[8]  = '{1, 8'hAA, 1, 0, 8'h00, 0};
    tbl[9]  = '{1, 8'h15, 0, 1, 8'h15, 0};
    tbl[10] = '{1, 8'h1D, 0, 1, 8'h15, 0};
    tbl[11] = '{1, 8'h24, 0, 1, 8'h15, 0};
    tbl[12] = '{1, 8'h2D, 0, 1, 8'h15, 0};
    tbl[13] = '{1, 8'h2C, 0, 1, 8'h15, 1};
    tbl[14] = '{0, 8'h00, 1, 1, 8'h1D, 1};
    tbl[15] = '{0, 8'h00, 1, 1, 8'h24, 1};
    tbl[16] = '{0, 8'h00, 1, 1, 8'h2D, 1};
    tbl[17] = '{0, 8'h00, 1, 0, 8'h00, 1};
    fill  = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    drain = '{8'h1D, 8'h24, 8'h2D, 8'h2C};
    pool  = '{8'h1C, 8'h75, 8'h15, 8'hF0, 8'hE0, 8'hAA, 8'h00, 8'hFF, 8'h2C, 8'hF0};

    // Reset state, both while asserted and after release.
    #2;
    expect_out("reset_held", 0, 8'h00, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_out("reset_released", 0, 8'h00, 0, 0);

    // Single make, repeat filtering, FIFO fill and overflow.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].f, tbl[i].b, tbl[i].r);
      expect_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].c, 1'b0, tbl[i].o);
    end

    // Asynchronous reset mid-sequence discards the pending E0.
    drive(1, 8'h1C, 0);
    expect_out("pre_rst", 1, 8'h1C, 0, 1);
    drive(1, 8'hE0, 0);
    expect_out("after_e0", 1, 8'h1C, 0, 1);
    reset = 1'b0;
    #2;
    expect_out("async_rst", 0, 8'h00, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1, 8'h75, 0);
    expect_out("rst_discard", 1, 8'h75, 0, 0);
    drive(0, 8'h00, 1);
    expect_out("rst_drain", 0, 8'h00, 0, 0);

    // Extended make, extended break clears held, re-press gives a new event.
    do_reset();
    drive(1, 8'hE0, 0);
    expect_out("e0_only", 0, 8'h00, 0, 0);
    drive(1, 8'h75, 0);
    expect_out("ext_make", 1, 8'h75, EXT_EN, 0);
    drive(1, 8'hE0, 0);
    drive(1, 8'hF0, 0);
    drive(1, 8'h75, 0);
    expect_out("ext_break", 1, 8'h75, EXT_EN, 0);
    drive(1, 8'hE0, 0);
    drive(1, 8'h75, 0);
    expect_out("ext_remake", 1, 8'h75, EXT_EN, 0);
    drive(0, 8'h00, 1);
    expect_out("ext_pop1", 1, 8'h75, EXT_EN, 0);
    drive(0, 8'h00, 1);
    expect_out("ext_pop2", 0, 8'h00, 0, 0);

    // Full FIFO with simultaneous push and pop: no loss, no overflow.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, fill[i], 0);
    expect_out("full_head", 1, 8'h15, 0, 0);
    drive(1, 8'h2C, 1);
    expect_out("full_pushpop", 1, 8'h1D, 0, 0);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("full_drain%0d", i), 1, drain[i], 0, 0);
      drive(0, 8'h00, 1);
    end
    expect_out("full_empty", 0, 8'h00, 0, 0);

    // Empty FIFO, push with ready high: no pop of the new event.
    drive(1, 8'h33, 1);
    expect_out("empty_push_ready", 1, 8'h33, 0, 0);
    drive(0, 8'h00, 1);
    expect_out("empty_push_drain", 0, 8'h00, 0, 0);

    // Random traffic against the reference model, varying downstream readiness.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      model_clear();
      for (int i = 0; i < 600; i++) begin
        rf = ($urandom_range(0, 1) == 1);
        rb = pool[$urandom_range(0, 9)];
        rr = ($urandom_range(0, 3) <= blk);
        drive(rf, rb, rr);
        model_edge(rf, rb, rr);
        check($sformatf("rnd%0d_%0d.valid", blk, i), 32'(ev_valid), 32'(q.size() != 0));
        check($sformatf("rnd%0d_%0d.code", blk, i), 32'(ev_code),
              32'((q.size() != 0) ? q[0].code : 8'h00));
        check($sformatf("rnd%0d_%0d.ext", blk, i), 32'(ev_ext),
              32'((q.size() != 0) ? q[0].ext : 1'b0));
        check($sformatf("rnd%0d_%0d.ovf", blk, i), 32'(overflow), 32'(m_ovf));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kbd_event_filter.md
KBD_EVENT_FILTER -- requirements
Module: kbd_event_filter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered key events (power of two, 2..16).
REQ-002 Parameter DROP_REPEAT, default 1, when 1 typematic repeats of a held key are discarded.
REQ-003 clk  input  1  system clock (the clkdiv4 pixel-rate domain).
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 flag  input  1  one-cycle strobe, scancode byte valid from the PS/2 protocol stage.
REQ-006 scancode  input  8  raw received byte.
REQ-007 ev_ready  input  1  downstream decoder accepts the head event.
REQ-008 ev_valid  output  1  FIFO non-empty, head event presented.
REQ-009 ev_code  output  8  make code of the head event.
REQ-010 ev_ext  output  1  head event was E0-prefixed.
REQ-011 overflow  output  1  sticky, an event was lost to a full FIFO.

Function
REQ-012 Prefix FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 then F0); advances only on a cycle with flag=1.
REQ-013 IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte -> make event (ext=0), stay IDLE.
REQ-014 EXT: 0xF0 -> EXT_BRK; 0xE0 -> EXT; other byte -> make event (ext=1), -> IDLE.
REQ-015 BRK / EXT_BRK: any byte -> break of that code (ext=0 / ext=1), no event pushed, -> IDLE.
REQ-016 Bytes 0xAA, 0xFA, 0xFE, 0xEE, 0x00 and 0xFF in IDLE are discarded; state unchanged.
REQ-017 A held register {held_valid, held_ext, held_code} records the last pushed make; a break matching held_code and held_ext clears held_valid; a non-matching break leaves it unchanged.
REQ-018 With DROP_REPEAT=1, a make equal to the held {ext,code} while held_valid=1 is discarded; any other make is pushed and replaces held.
REQ-019 Push latency: event visible on ev_valid/ev_code/ev_ext the cycle after the flag cycle carrying the final byte.
REQ-020 Pop: head advances on a cycle where ev_valid=1 and ev_ready=1; ev_code/ev_ext stay stable while ev_valid=1 and ev_ready=0.
REQ-021 FIFO full plus push with no pop in the same cycle: event dropped, overflow set to 1, held register still updated.
REQ-022 Full, push and pop in the same cycle: both performed, count unchanged, no overflow.
REQ-023 Empty, push and ev_ready=1: push performed, no pop (ev_valid was 0), count becomes 1.
REQ-024 Read/write pointers wrap modulo FIFO_DEPTH; count is held in $clog2(FIFO_DEPTH)+1 bits.
REQ-025 overflow clears only on reset.

Reset
REQ-026 reset low, asynchronously: FSM=IDLE, pointers and count=0, held_valid=0, overflow=0, ev_valid=0, ev_code=0x00, ev_ext=0.
REQ-027 Reset mid-sequence (after E0 or F0) discards the partial sequence; the next byte is treated from IDLE.

Configuration
REQ-028 Macro KBD_EXT_PREFIX_EN defined: E0 handling as in REQ-013..015.
REQ-029 Macro KBD_EXT_PREFIX_EN undefined: EXT and EXT_BRK are not implemented; 0xE0 in IDLE is discarded; ev_ext is tied 0; the held register omits ext.

Structure
REQ-030 Shared package kbd_pkg holds: PS/2 constants (BREAK=0xF0, EXT=0xE0, BAT_OK=0xAA, ACK=0xFA, RESEND=0xFE, ECHO=0xEE), the FSM state enum, and an event struct {ext, code}.
REQ-031 One sub-module, kbd_event_fifo (parameterised depth, valid/ready pop, full/empty); the FSM and held logic stay in kbd_event_filter.

Verification
REQ-032 Bytes 0x1C -> one event code=0x1C ext=0, ev_valid the cycle after the flag cycle.
REQ-033 0x1C, 0x1C, 0x1C, then 0xF0 0x1C, then 0x1C with DROP_REPEAT=1 -> exactly two events, both 0x1C.
REQ-034 0xE0 0x75, then 0xE0 0xF0 0x75 -> one event code=0x75 ext=1; held cleared; next 0xE0 0x75 -> a new event.
REQ-035 ev_ready=0, FIFO_DEPTH=4, makes 0x15 0x1D 0x24 0x2D 0x2C -> four events in order, overflow=1, 0x2C lost.
REQ-036 FIFO full, ev_ready=1 and a make strobed in the same cycle -> count stays 4, overflow stays 0, order preserved.
REQ-037 0xE0 strobed, reset pulsed low, then 0x75 -> event ext=0, code=0x75; with KBD_EXT_PREFIX_EN undefined, 0xE0 0x75 -> event code=0x75, ext=0.
